// File: rtl/jtframe_pll_ctrl.sv
// jtframe_pll_ctrl
//
// Lock supervisor and reset sequencer for the system PLL. It runs on the PLL
// reference clock, pulses the PLL reset, waits for the PLL to report lock,
// requires lock to stay stable for a while, and only then releases the core
// reset. On lock loss, or when a relock is requested, the sequence runs again.
//
// Handshake note: req_relock has no ready/ack. Any cycle it is sampled high
// restarts the sequence from RESET_PLL. A level request keeps the PLL in reset
// for as long as it is held.
//
// Ports
//   clk         PLL reference clock
//   rst_n       asynchronous, active-low reset
//   locked      PLL lock flag (asynchronous to clk, synchronized here)
//   req_relock  request to re-run the lock sequence
//   pll_rst     reset to the PLL, active high
//   sys_rst     core reset, active high, deasserts synchronously
//   ready       high only while in RUN (complement of sys_rst)
//   fail_cnt    saturating count of lock timeouts
//   relock_cnt  saturating count of lock losses seen while in RUN
module jtframe_pll_ctrl #(
   parameter int RST_CYCLES    = 4096,
   parameter int LOCK_TIMEOUT  = 500000,
   parameter int STABLE_CYCLES = 65536,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             locked,
   input  logic             req_relock,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] relock_cnt
);

   // One shared timer, sized for the longest interval.
   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

   localparam logic [1:0] RESET_PLL = 2'd0;
   localparam logic [1:0] WAIT_LOCK = 2'd1;
   localparam logic [1:0] STABLE    = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [TW-1:0] timer;
   logic          timer_clr;
   logic          sync1;
   logic          locked_s;
   logic          fail_inc;
   logic          relock_inc;

   // Two-flop synchronizer for the asynchronous lock flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync1    <= locked;
         locked_s <= sync1;
      end
   end

   // Next-state logic. Outside RUN a relock request wins over everything and
   // never touches the counters. In RUN, lock loss is checked first so that a
   // coincident request still counts the loss exactly once.
   always_comb begin
      state_nxt  = state;
      fail_inc   = 1'b0;
      relock_inc = 1'b0;
      case (state)
         RESET_PLL: begin
            if (req_relock)             state_nxt = RESET_PLL;
            else if (timer == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (req_relock) begin
               state_nxt = RESET_PLL;
            end else if (locked_s) begin
               state_nxt = STABLE;
            end else if (timer == TIMEOUT_LAST) begin
               state_nxt = RESET_PLL;
               fail_inc  = 1'b1;
            end
         end
         STABLE: begin
            if (req_relock)                state_nxt = RESET_PLL;
            else if (!locked_s)            state_nxt = WAIT_LOCK;
            else if (timer == STABLE_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt  = RESET_PLL;
               relock_inc = 1'b1;
            end else if (req_relock) begin
               state_nxt  = RESET_PLL;
            end
         end
         default: state_nxt = RESET_PLL;
      endcase
   end

   // The timer restarts on any state change and on a request (which restarts
   // the PLL reset hold even when already in RESET_PLL). It is idle in RUN.
   always_comb begin
      timer_clr = (state_nxt != state) || req_relock || (state == RUN);
   end

   // State, timer, counters and outputs all update on the same edge; outputs
   // are decoded from the next state so they are registered, not combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_PLL;
         timer      <= '0;
         pll_rst    <= 1'b1;
         sys_rst    <= 1'b1;
         ready      <= 1'b0;
         fail_cnt   <= '0;
         relock_cnt <= '0;
      end else begin
         state   <= state_nxt;
         timer   <= timer_clr ? '0 : timer + 1'b1;
         pll_rst <= (state_nxt == RESET_PLL);
         sys_rst <= (state_nxt != RUN);
         ready   <= (state_nxt == RUN);
         if (fail_inc && (fail_cnt != {CNT_W{1'b1}}))
            fail_cnt <= fail_cnt + 1'b1;
         if (relock_inc && (relock_cnt != {CNT_W{1'b1}}))
            relock_cnt <= relock_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_jtframe_pll_ctrl.sv
// Directed bench for jtframe_pll_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, CNT_W=4. Edge numbers in comments count rising edges from
// the step's reference point; outputs are sampled 1 ns after each edge.
module tb_jtframe_pll_ctrl;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       req_relock;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic [3:0] fail_cnt;
   logic [3:0] relock_cnt;

   int checks   = 0;
   int failures = 0;

   jtframe_pll_ctrl #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .CNT_W        (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked    (locked),
      .req_relock(req_relock),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .ready     (ready),
      .fail_cnt  (fail_cnt),
      .relock_cnt(relock_cnt)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      locked     = 1'b1;
      req_relock = 1'b0;
      tick(2);
      check("rst_pll_rst", pll_rst, 1);
      check("rst_sys_rst", sys_rst, 1);
      check("rst_ready", ready, 0);
      check("rst_fail", fail_cnt, 0);
      check("rst_relock", relock_cnt, 0);

      // 1. Power-up with lock present: PLL reset edges 1-3, released on 4,
      //    RUN on edge 13.
      rst_n = 1'b1;
      tick(3);
      check("t1_pll_e3", pll_rst, 1);
      tick(1);
      check("t1_pll_e4", pll_rst, 0);
      check("t1_sys_e4", sys_rst, 1);
      tick(8);
      check("t1_sys_e12", sys_rst, 1);
      tick(1);
      check("t1_sys_e13", sys_rst, 0);
      check("t1_ready_e13", ready, 1);
      check("t1_fail", fail_cnt, 0);

      // 4. Lock loss in RUN: reaction on the 3rd edge, then full resequence.
      locked = 1'b0;
      tick(2);
      check("t4_sys_e2", sys_rst, 0);
      tick(1);
      check("t4_sys_e3", sys_rst, 1);
      check("t4_pll_e3", pll_rst, 1);
      check("t4_ready_e3", ready, 0);
      check("t4_relock", relock_cnt, 1);
      locked = 1'b1;
      tick(12);
      check("t4_sys_r12", sys_rst, 1);
      tick(1);
      check("t4_ready_r13", ready, 1);

      // 5a. Relock request in RUN: RESET_PLL next edge, no count.
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      check("t5_pll", pll_rst, 1);
      check("t5_sys", sys_rst, 1);
      check("t5_relock", relock_cnt, 1);
      tick(12);
      check("t5_sys_r12", sys_rst, 1);
      tick(1);
      check("t5_ready_r13", ready, 1);

      // 5b. Request on the same cycle the synchronized lock falls: one count.
      locked = 1'b0;
      tick(2);
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      check("t5b_pll", pll_rst, 1);
      check("t5b_relock", relock_cnt, 2);

      // 3. One-cycle lock drop while STABLE timer=5 (edge Z+11): back to
      //    WAIT_LOCK, RUN delayed from Z+13 to Z+20.
      locked = 1'b1;
      tick(8);
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(4);
      check("t3_sys_z13", sys_rst, 1);
      check("t3_pll_z13", pll_rst, 0);
      tick(6);
      check("t3_sys_z19", sys_rst, 1);
      tick(1);
      check("t3_ready_z20", ready, 1);
      check("t3_relock", relock_cnt, 2);

      // 6. Async reset mid-STABLE, between edges.
      req_relock = 1'b1;
      tick(1);
      req_relock = 1'b0;
      tick(8);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_pll", pll_rst, 1);
      check("t6_sys", sys_rst, 1);
      check("t6_ready", ready, 0);
      check("t6_fail", fail_cnt, 0);
      check("t6_relock", relock_cnt, 0);

      // 2. No lock: 24-cycle retry period, fail_cnt saturates at 15.
      locked = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(23);
      check("t2_fail_e23", fail_cnt, 0);
      check("t2_pll_e23", pll_rst, 0);
      tick(1);
      check("t2_fail_e24", fail_cnt, 1);
      check("t2_pll_e24", pll_rst, 1);
      tick(3);
      check("t2_pll_e27", pll_rst, 1);
      tick(1);
      check("t2_pll_e28", pll_rst, 0);
      tick(20);
      check("t2_fail_e48", fail_cnt, 2);
      check("t2_pll_e48", pll_rst, 1);
      tick(24 * 13 - 1);
      check("t2_fail_e359", fail_cnt, 14);
      tick(1);
      check("t2_fail_e360", fail_cnt, 15);
      tick(24 * 2);
      check("t2_fail_sat", fail_cnt, 15);
      check("t2_sys", sys_rst, 1);
      check("t2_relock", relock_cnt, 0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
